rb_window_gen: RTL and testbench

Parametrised row-buffer window generator for neighbourhood image processing. Accepts a raster-scan pixel stream and stores the last K-1 image rows in K-1 circular BRAM line banks. Emits one K-pixel vertical column per accepted pixel once K-1 rows are buffered. It uses a valid/ready handshake on both sides, replacing the fixed-timing control/address/steer datapath with a single back-pressurable block.

---
 rtl/rb_window_gen_if.sv | 32 +++
 rtl/rb_window_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_rb_window_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rb_window_gen_if.sv
// Pixel-stream interface for rb_window_gen: input pixel handshake and output
// column handshake. The block itself uses the slave view; a source/sink
// (for example a testbench) uses the master view.
interface rb_window_gen_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int K           = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_WIDTH-1:0]     in_pixel;
    logic                       out_valid;
    logic                       out_ready;
    logic [K*PIXEL_WIDTH-1:0]   out_col;

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_col
    );

    modport master (
        output in_valid,
        output in_pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_col
    );
endinterface

// File: rtl/rb_window_gen.sv
// rb_window_gen: row-buffer window generator. Stores the last K-1 image rows
// in K-1 circular read-first line banks and emits one K-pixel vertical column
// per accepted pixel once K-1 rows are buffered. One-stage pipeline with
// valid/ready on both sides.
// Optional feature: define RB_COORD_EN to add out_x/out_y coordinate outputs.
module rb_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int K           = 3,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    rb_window_gen_if.slave     bus,
    output logic               busy,
    output logic               complete
`ifdef RB_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y
`endif
);
    localparam int XW  = $clog2(IMG_WIDTH);
    localparam int YW  = $clog2(IMG_HEIGHT);
    localparam int NB  = K - 1;
    localparam int WBW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [XW-1:0]  X_LAST      = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST      = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0]  Y_FILL_LAST = YW'(K - 2);
    localparam logic [WBW-1:0] WB_LAST     = WBW'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [WBW-1:0]         wb_q, wb_d;
    logic                   last_acc_q, last_acc_d;
    logic                   out_valid_q, out_valid_d;
    logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
    logic [WBW-1:0]         wb_sel_q, wb_sel_d;
    logic                   busy_q, busy_d;
    logic                   complete_q, complete_d;
`ifdef RB_COORD_EN
    logic [XW-1:0]          ox_q, ox_d;
    logic [YW-1:0]          oy_q, oy_d;
`endif

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   emit_s;
    logic [PIXEL_WIDTH-1:0] bank_rd_s [NB];
    logic [K*PIXEL_WIDTH-1:0] col_s;

    // Input is taken only while a frame is open, the last pixel has not yet
    // been taken, and the single output slot is free or being drained.
    assign in_ready_s = ((state_q == S_FILL) || (state_q == S_STREAM)) && !last_acc_q
                        && (!out_valid_q || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign emit_s     = out_valid_q && bus.out_ready;

    // One read-first line bank per stored row; all banks read on accept,
    // only the current write bank is overwritten with the incoming pixel.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [PIXEL_WIDTH-1:0] mem [IMG_WIDTH];
        logic [PIXEL_WIDTH-1:0] rd_q;

        // Bank read/write port, enabled only by an accepted pixel.
        always_ff @(posedge clk) begin
            if (accept_s) begin
                rd_q <= mem[x_q];
                if (wb_q == WBW'(b)) begin
                    mem[x_q] <= bus.in_pixel;
                end
            end
        end

        assign bank_rd_s[b] = rd_q;
    end

    // Newest pixel sits in the top slice; slice i rows below it comes from
    // bank (wb - i) mod (K-1), using the write bank captured at accept.
    assign col_s[K*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = pix_q;
    for (genvar i = 1; i < K; i++) begin : g_steer
        logic [WBW-1:0] src_s;
        assign src_s = (wb_sel_q >= WBW'(i)) ? (wb_sel_q - WBW'(i))
                                             : (wb_sel_q + WBW'(NB - i));
        assign col_s[(K-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH] = bank_rd_s[src_s];
    end

    // Frame FSM, raster counters, write-bank pointer and output slot.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        wb_d        = wb_q;
        last_acc_d  = last_acc_q;
        out_valid_d = out_valid_q;
        pix_d       = pix_q;
        wb_sel_d    = wb_sel_q;
`ifdef RB_COORD_EN
        ox_d        = ox_q;
        oy_d        = oy_q;
`endif
        case (state_q)
            S_IDLE: begin
                x_d        = XW'(0);
                y_d        = YW'(0);
                wb_d       = WBW'(0);
                last_acc_d = 1'b0;
                if (start) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (accept_s && (x_q == X_LAST) && (y_q == Y_FILL_LAST)) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_STREAM: begin
                if (last_acc_q && emit_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept_s) begin
            pix_d    = bus.in_pixel;
            wb_sel_d = wb_q;
`ifdef RB_COORD_EN
            ox_d     = x_q;
            oy_d     = y_q;
`endif
            if (x_q == X_LAST) begin
                x_d  = XW'(0);
                y_d  = (y_q == Y_LAST) ? YW'(0) : (y_q + YW'(1));
                wb_d = (wb_q == WB_LAST) ? WBW'(0) : (wb_q + WBW'(1));
            end else begin
                x_d  = x_q + XW'(1);
            end
            if ((state_q == S_STREAM) && (x_q == X_LAST) && (y_q == Y_LAST)) begin
                last_acc_d = 1'b1;
            end else begin
                last_acc_d = last_acc_q;
            end
        end else begin
            pix_d = pix_q;
        end

        if (accept_s && (state_q == S_STREAM)) begin
            out_valid_d = 1'b1;
        end else if (emit_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        busy_d     = (state_d != S_IDLE);
        complete_d = (state_d == S_DONE);
    end

    // Control and output registers with synchronous reset; a reset drops any
    // pending column and abandons the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= XW'(0);
            y_q         <= YW'(0);
            wb_q        <= WBW'(0);
            last_acc_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pix_q       <= PIXEL_WIDTH'(0);
            wb_sel_q    <= WBW'(0);
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
`ifdef RB_COORD_EN
            ox_q        <= XW'(0);
            oy_q        <= YW'(0);
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wb_q        <= wb_d;
            last_acc_q  <= last_acc_d;
            out_valid_q <= out_valid_d;
            pix_q       <= pix_d;
            wb_sel_q    <= wb_sel_d;
            busy_q      <= busy_d;
            complete_q  <= complete_d;
`ifdef RB_COORD_EN
            ox_q        <= ox_d;
            oy_q        <= oy_d;
`endif
        end
    end

    // Bank contents are never reset, so the column is forced to zero whenever
    // no valid column is held.
    assign bus.out_col   = out_valid_q ? col_s : {(K*PIXEL_WIDTH){1'b0}};
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_s;
    assign busy          = busy_q;
    assign complete      = complete_q;
`ifdef RB_COORD_EN
    assign out_x         = ox_q;
    assign out_y         = oy_q;
`endif

endmodule

// File: tb/tb_rb_window_gen.sv
// Directed testbench for rb_window_gen with K=3, 4x4 image, pixel = 16*y+x.
module tb_rb_window_gen;
    localparam int PW = 8;
    localparam int KK = 3;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic complete;
`ifdef RB_COORD_EN
    logic [1:0] out_x;
    logic [1:0] out_y;
`endif

    rb_window_gen_if #(.PIXEL_WIDTH(PW), .K(KK)) bus ();

    rb_window_gen #(
        .PIXEL_WIDTH(PW), .K(KK), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .complete(complete)
`ifdef RB_COORD_EN
        ,
        .out_x(out_x),
        .out_y(out_y)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] got_col[$];
    int got_x[$];
    int got_y[$];
    int first_valid_cyc, accepts_at_first_valid, first_ready_cyc, valid_cnt;
    int complete_cnt, complete_cyc, last_emit_cyc, busy_drop_cyc;
    int hold_bad, ready_in_stall, ready_after_last;
    bit timed_out;

    function automatic logic [23:0] exp_col(input int i);
        int y;
        int x;
        y = 2 + i / 4;
        x = i % 4;
        return {8'(16 * y + x), 8'(16 * (y - 1) + x), 8'(16 * (y - 2) + x)};
    endfunction

    // Drives one frame and records what the DUT did; the calling test checks it.
    task automatic run_frame(input bit bubbles, input int stall_col, input int stall_cyc,
                             input int start_at_pix, input int rst_at_pix);
        int pix;
        int cyc;
        int stall_left;
        bit stall_done;
        bit v;
        bit r;
        logic [23:0] c;
        logic [23:0] stall_val;
        pix = 0; cyc = 0; stall_left = 0; stall_done = 1'b0; stall_val = 24'h0;
        got_col.delete(); got_x.delete(); got_y.delete();
        first_valid_cyc = -1; accepts_at_first_valid = -1; first_ready_cyc = -1;
        valid_cnt = 0; complete_cnt = 0; complete_cyc = -1; last_emit_cyc = -1;
        busy_drop_cyc = -1; hold_bad = 0; ready_in_stall = 0; ready_after_last = 0;
        timed_out = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            if (cyc >= 200) begin
                timed_out = 1'b1;
                break;
            end
            v = bus.out_valid;
            c = bus.out_col;
            if (complete === 1'b1) begin
                complete_cnt++;
                complete_cyc = cyc;
            end
            if (complete_cnt > 0 && busy === 1'b0) begin
                busy_drop_cyc = cyc;
                break;
            end
            if (v && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                accepts_at_first_valid = pix;
            end
            if (v) valid_cnt++;
            if (rst_at_pix >= 0 && pix == rst_at_pix) begin
                rst = 1'b1; bus.in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (v && !stall_done && got_col.size() == stall_col) begin
                stall_left = stall_cyc; stall_done = 1'b1; stall_val = c;
            end
            if (stall_left > 0 && c !== stall_val) hold_bad++;
            bus.out_ready = (stall_left == 0);
            bus.in_valid  = (pix < 16) && (!bubbles || (cyc % 2 == 0));
            bus.in_pixel  = 8'(16 * (pix / 4) + pix % 4);
            start         = (pix == start_at_pix);
            #1;
            r = bus.in_ready;
            if (r && first_ready_cyc < 0) first_ready_cyc = cyc;
            if (r && stall_left > 0) ready_in_stall++;
            if (r && pix >= 16) ready_after_last++;
            if (r && bus.in_valid) pix++;
            if (v && bus.out_ready) begin
                got_col.push_back(c);
`ifdef RB_COORD_EN
                got_x.push_back(int'(out_x));
                got_y.push_back(int'(out_y));
`endif
                last_emit_cyc = cyc;
            end
            if (stall_left > 0) stall_left--;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0; start = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_pixel = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_col !== 24'h0) begin miscompares++; $display("FAIL reset_out_col: got %06h want 000000", bus.out_col); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete: got %0b want 0", complete); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: busy %0b in_ready %0b want 0 0", busy, bus.in_ready); end
    endtask

    task automatic test_full_rate();
        run_frame(1'b0, -1, 0, -1, -1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL full_timeout: frame did not finish in 200 cycles"); end
        vectors++; if (first_ready_cyc !== 0) begin miscompares++; $display("FAIL full_first_ready: got cycle %0d want 0", first_ready_cyc); end
        vectors++; if (first_valid_cyc !== 9) begin miscompares++; $display("FAIL full_first_valid: got cycle %0d want 9", first_valid_cyc); end
        vectors++; if (accepts_at_first_valid !== 9) begin miscompares++; $display("FAIL full_fill_count: got %0d want 9", accepts_at_first_valid); end
        vectors++; if (got_col.size() !== 8) begin miscompares++; $display("FAIL full_col_count: got %0d want 8", got_col.size()); end
        for (int i = 0; i < got_col.size() && i < 8; i++) begin
            vectors++; if (got_col[i] !== exp_col(i)) begin miscompares++; $display("FAIL full_col[%0d]: got %06h want %06h", i, got_col[i], exp_col(i)); end
        end
        if (got_col.size() == 8) begin
            vectors++; if (got_col[0] !== 24'h201000) begin miscompares++; $display("FAIL full_first_col: got %06h want 201000", got_col[0]); end
            vectors++; if (got_col[7] !== 24'h332313) begin miscompares++; $display("FAIL full_last_col: got %06h want 332313", got_col[7]); end
        end
        vectors++; if (complete_cnt !== 1) begin miscompares++; $display("FAIL full_complete_cnt: got %0d want 1", complete_cnt); end
        vectors++; if (complete_cyc - last_emit_cyc !== 1) begin miscompares++; $display("FAIL full_complete_gap: got %0d want 1", complete_cyc - last_emit_cyc); end
        vectors++; if (busy_drop_cyc - complete_cyc !== 1) begin miscompares++; $display("FAIL full_busy_gap: got %0d want 1", busy_drop_cyc - complete_cyc); end
        vectors++; if (valid_cnt !== 8) begin miscompares++; $display("FAIL full_valid_cycles: got %0d want 8", valid_cnt); end
        vectors++; if (ready_after_last !== 0) begin miscompares++; $display("FAIL full_ready_after_last: got %0d want 0", ready_after_last); end
    endtask

    task automatic test_backpressure();
        run_frame(1'b0, 1, 3, -1, -1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL bp_timeout: frame did not finish in 200 cycles"); end
        vectors++; if (got_col.size() !== 8) begin miscompares++; $display("FAIL bp_col_count: got %0d want 8", got_col.size()); end
        for (int i = 0; i < got_col.size() && i < 8; i++) begin
            vectors++; if (got_col[i] !== exp_col(i)) begin miscompares++; $display("FAIL bp_col[%0d]: got %06h want %06h", i, got_col[i], exp_col(i)); end
        end
        if (got_col.size() > 2) begin
            vectors++; if (got_col[1] !== 24'h211101) begin miscompares++; $display("FAIL bp_stalled_col: got %06h want 211101", got_col[1]); end
            vectors++; if (got_col[2] !== 24'h221202) begin miscompares++; $display("FAIL bp_next_col: got %06h want 221202", got_col[2]); end
        end
        vectors++; if (hold_bad !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d changes want 0", hold_bad); end
        vectors++; if (ready_in_stall !== 0) begin miscompares++; $display("FAIL bp_in_ready: got %0d ready cycles want 0", ready_in_stall); end
        vectors++; if (valid_cnt !== 11) begin miscompares++; $display("FAIL bp_valid_cycles: got %0d want 11", valid_cnt); end
        vectors++; if (last_emit_cyc !== 19) begin miscompares++; $display("FAIL bp_last_emit: got cycle %0d want 19", last_emit_cyc); end
        vectors++; if (complete_cnt !== 1) begin miscompares++; $display("FAIL bp_complete_cnt: got %0d want 1", complete_cnt); end
    endtask

    task automatic test_bubbles();
        run_frame(1'b1, -1, 0, -1, -1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL bub_timeout: frame did not finish in 200 cycles"); end
        vectors++; if (got_col.size() !== 8) begin miscompares++; $display("FAIL bub_col_count: got %0d want 8", got_col.size()); end
        for (int i = 0; i < got_col.size() && i < 8; i++) begin
            vectors++; if (got_col[i] !== exp_col(i)) begin miscompares++; $display("FAIL bub_col[%0d]: got %06h want %06h", i, got_col[i], exp_col(i)); end
        end
        vectors++; if (first_valid_cyc !== 17) begin miscompares++; $display("FAIL bub_first_valid: got cycle %0d want 17", first_valid_cyc); end
        vectors++; if (valid_cnt !== 8) begin miscompares++; $display("FAIL bub_valid_cycles: got %0d want 8", valid_cnt); end
        vectors++; if (last_emit_cyc !== 31) begin miscompares++; $display("FAIL bub_last_emit: got cycle %0d want 31", last_emit_cyc); end
        vectors++; if (complete_cnt !== 1) begin miscompares++; $display("FAIL bub_complete_cnt: got %0d want 1", complete_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(1'b0, -1, 0, -1, 9);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_col !== 24'h0) begin miscompares++; $display("FAIL midrst_out_col: got %06h want 000000", bus.out_col); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready: got %0b want 0", bus.in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        vectors++; if (complete !== 1'b0) begin miscompares++; $display("FAIL midrst_complete: got %0b want 0", complete); end
        run_frame(1'b0, -1, 0, -1, -1);
        vectors++; if (got_col.size() !== 8) begin miscompares++; $display("FAIL midrst_col_count: got %0d want 8", got_col.size()); end
        for (int i = 0; i < got_col.size() && i < 8; i++) begin
            vectors++; if (got_col[i] !== exp_col(i)) begin miscompares++; $display("FAIL midrst_col[%0d]: got %06h want %06h", i, got_col[i], exp_col(i)); end
        end
        vectors++; if (last_emit_cyc !== 16) begin miscompares++; $display("FAIL midrst_last_emit: got cycle %0d want 16", last_emit_cyc); end
        vectors++; if (complete_cnt !== 1) begin miscompares++; $display("FAIL midrst_complete_cnt: got %0d want 1", complete_cnt); end
    endtask

    task automatic test_start_during_stream();
        run_frame(1'b0, -1, 0, 10, -1);
        vectors++; if (got_col.size() !== 8) begin miscompares++; $display("FAIL sds_col_count: got %0d want 8", got_col.size()); end
        for (int i = 0; i < got_col.size() && i < 8; i++) begin
            vectors++; if (got_col[i] !== exp_col(i)) begin miscompares++; $display("FAIL sds_col[%0d]: got %06h want %06h", i, got_col[i], exp_col(i)); end
        end
        vectors++; if (last_emit_cyc !== 16) begin miscompares++; $display("FAIL sds_last_emit: got cycle %0d want 16", last_emit_cyc); end
        vectors++; if (complete_cnt !== 1) begin miscompares++; $display("FAIL sds_complete_cnt: got %0d want 1", complete_cnt); end
`ifdef RB_COORD_EN
        if (got_x.size() == 8) begin
            vectors++; if (got_x[0] !== 0 || got_y[0] !== 2) begin miscompares++; $display("FAIL coord_first: got x=%0d y=%0d want x=0 y=2", got_x[0], got_y[0]); end
            vectors++; if (got_x[7] !== 3 || got_y[7] !== 3) begin miscompares++; $display("FAIL coord_last: got x=%0d y=%0d want x=3 y=3", got_x[7], got_y[7]); end
        end else begin
            vectors++; miscompares++; $display("FAIL coord_count: got %0d want 8", got_x.size());
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'h00;
        bus.out_ready = 1'b1;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_bubbles();
        test_reset_mid_frame();
        test_start_during_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
